// File: rtl/gather_sched_ctrl.sv
// gather_sched_ctrl
//   Sequencer for the data_gather datapath. For each kernel group it accepts
//   n_channel beats from the tiling machine into the accumulators, waits a fixed
//   drain window, then issues READS_PER_GROUP read requests to the gather SRAM.
//   Each request must see its completion before the next one is issued.
//   After n_kernel groups it pulses o_done and returns to IDLE.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             start pulse (only looked at in IDLE)
//   i_abort             synchronous abort back to IDLE from any state
//   i_cfg_n_channel     channels per kernel group (1..N_CHANNEL_MAX)
//   i_cfg_n_kernel      kernel groups per run (1..NO_OF_KERNEL)
//   i_tile_valid        upstream beat valid
//   o_tile_ready        upstream ready (combinational, high in ACCUM)
//   o_accum_valid       accumulate strobe (combinational, valid & ready)
//   o_read_req          one-cycle read request to the writer
//   i_wr_ready          writer can accept a read request
//   i_gather_valid      read completion
//   o_kernel_idx        current kernel group
//   o_channel_idx       beats accepted in the current group
//   o_busy              high whenever not in IDLE
//   o_done              one-cycle pulse at run completion
//   o_cfg_err           one-cycle pulse when a start is rejected
module gather_sched_ctrl #(
    parameter int N_CHANNEL_MAX   = 32,
    parameter int NO_OF_KERNEL    = 16,
    parameter int FLUSH_CYCLES    = 3,
    parameter int READS_PER_GROUP = 4,
    parameter int CH_W            = $clog2(N_CHANNEL_MAX + 1),
    parameter int KN_W            = $clog2(NO_OF_KERNEL + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [CH_W-1:0] i_cfg_n_channel,
    input  logic [KN_W-1:0] i_cfg_n_kernel,
    input  logic            i_tile_valid,
    output logic            o_tile_ready,
    output logic            o_accum_valid,
    output logic            o_read_req,
    input  logic            i_wr_ready,
    input  logic            i_gather_valid,
    output logic [KN_W-1:0] o_kernel_idx,
    output logic [CH_W-1:0] o_channel_idx,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_cfg_err
);

    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
    localparam int RD_W = $clog2(READS_PER_GROUP + 1);

    localparam logic [CH_W-1:0] CH_MAX  = CH_W'(N_CHANNEL_MAX);
    localparam logic [KN_W-1:0] KN_MAX  = KN_W'(NO_OF_KERNEL);
    localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLUSH_CYCLES);
    localparam logic [RD_W-1:0] RD_MAX  = RD_W'(READS_PER_GROUP);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(READS_PER_GROUP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_READ,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          state;
    logic [CH_W-1:0] n_ch_q;
    logic [KN_W-1:0] n_kn_q;
    logic [FL_W-1:0] flush_cnt;
    logic [RD_W-1:0] issued;
    logic [RD_W-1:0] completed;
    logic            outstanding;

    logic cfg_ok;
    logic beat_last;
    logic kern_last;
    logic req_fire;
    logic cpl_fire;

    assign cfg_ok = (i_cfg_n_channel != '0) && (i_cfg_n_channel <= CH_MAX) &&
                    (i_cfg_n_kernel  != '0) && (i_cfg_n_kernel  <= KN_MAX);

    assign o_tile_ready  = (state == S_ACCUM);
    assign o_accum_valid = i_tile_valid & o_tile_ready;

    assign beat_last = (o_channel_idx == n_ch_q - CH_W'(1));
    assign kern_last = (o_kernel_idx  == n_kn_q - KN_W'(1));

    // outstanding is the registered flag, so a completion and a new request
    // can never land on the same edge: requests are at least 2 cycles apart.
    assign req_fire = i_wr_ready && !outstanding && (issued < RD_MAX);
    assign cpl_fire = i_gather_valid && outstanding;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            n_ch_q        <= '0;
            n_kn_q        <= '0;
            flush_cnt     <= '0;
            issued        <= '0;
            completed     <= '0;
            outstanding   <= 1'b0;
            o_kernel_idx  <= '0;
            o_channel_idx <= '0;
            o_read_req    <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_cfg_err     <= 1'b0;
        end else begin
            // pulse outputs default low every cycle
            o_read_req <= 1'b0;
            o_done     <= 1'b0;
            o_cfg_err  <= 1'b0;

            if (i_abort) begin
                // abort wins over every transition, including a same-cycle start
                state         <= S_IDLE;
                flush_cnt     <= '0;
                issued        <= '0;
                completed     <= '0;
                outstanding   <= 1'b0;
                o_kernel_idx  <= '0;
                o_channel_idx <= '0;
                o_busy        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            if (cfg_ok) begin
                                n_ch_q        <= i_cfg_n_channel;
                                n_kn_q        <= i_cfg_n_kernel;
                                o_kernel_idx  <= '0;
                                o_channel_idx <= '0;
                                o_busy        <= 1'b1;
                                state         <= S_ACCUM;
                            end else begin
                                o_cfg_err <= 1'b1;
                            end
                        end
                    end

                    S_ACCUM: begin
                        // gaps in i_tile_valid simply stall here
                        if (i_tile_valid) begin
                            o_channel_idx <= o_channel_idx + CH_W'(1);
                            if (beat_last) begin
                                flush_cnt <= FL_LOAD;
                                state     <= S_FLUSH;
                            end
                        end
                    end

                    S_FLUSH: begin
                        // loaded with FLUSH_CYCLES, leaves on the cycle it reads 1
                        if (flush_cnt <= FL_W'(1)) begin
                            flush_cnt   <= '0;
                            issued      <= '0;
                            completed   <= '0;
                            outstanding <= 1'b0;
                            state       <= S_READ;
                        end else begin
                            flush_cnt <= flush_cnt - FL_W'(1);
                        end
                    end

                    S_READ: begin
                        if (req_fire) begin
                            o_read_req  <= 1'b1;
                            outstanding <= 1'b1;
                            issued      <= issued + RD_W'(1);
                        end else if (cpl_fire) begin
                            outstanding <= 1'b0;
                            completed   <= completed + RD_W'(1);
                            if (completed == RD_LAST) begin
                                state <= S_NEXT;
                            end
                        end
                    end

                    S_NEXT: begin
                        o_channel_idx <= '0;
                        if (kern_last) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            o_kernel_idx <= o_kernel_idx + KN_W'(1);
                            state        <= S_ACCUM;
                        end
                    end

                    S_DONE: begin
                        // indices are left at their final values for observation
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end

                    default: begin
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/gather_sched_ctrl.md
Name: gather_sched_ctrl

Overview:
- Sequencer for the data_gather datapath.
- Per kernel group: streams N channel beats from the tiling machine into the accumulators, waits a fixed drain window, then issues READS_PER_GROUP read requests to the gather SRAM with a request/complete handshake. Each read completes on the gather valid.
- Repeats for n_kernel groups, then signals done.
- Sits between the layer-level control/config registers and data_gather.

Parameters:
N_CHANNEL_MAX, 32, max channels per kernel; legal i_cfg_n_channel is 1..N_CHANNEL_MAX
NO_OF_KERNEL, 16, max kernel groups; legal i_cfg_n_kernel is 1..NO_OF_KERNEL
FLUSH_CYCLES, 3, cycles spent in FLUSH after the last channel beat (must be >=1)
READS_PER_GROUP, 4, read requests per kernel group
CH_W, $clog2(N_CHANNEL_MAX+1), channel count width
KN_W, $clog2(NO_OF_KERNEL+1), kernel count width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_start  in  1  start pulse; sampled only in IDLE
i_abort  in  1  sync abort; returns block to IDLE from any state
i_cfg_n_channel  in  CH_W  channels per kernel
i_cfg_n_kernel  in  KN_W  kernel groups per run
i_tile_valid  in  1  upstream beat valid
o_tile_ready  out  1  upstream ready
o_accum_valid  out  1  accumulate strobe to datapath (i_valid_coming)
o_read_req  out  1  one-cycle read request (i_feature_writer_finish)
i_wr_ready  in  1  downstream writer can accept a read
i_gather_valid  in  1  read completion (o_gather_valid)
o_kernel_idx  out  KN_W  current kernel group
o_channel_idx  out  CH_W  channel beats accepted in current group
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse at run completion
o_cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk. All outputs go to 0, state to IDLE, all counters and the outstanding flag clear.
- States: IDLE, ACCUM, FLUSH, READ, NEXT, DONE. All outputs are registered except o_tile_ready and o_accum_valid, which are decoded combinationally from state.
- IDLE, i_start=1:
  - If n_channel is 0 or >N_CHANNEL_MAX, or n_kernel is 0 or >NO_OF_KERNEL: pulse o_cfg_err next cycle and stay in IDLE.
  - Otherwise: latch both config values, clear kernel_idx and channel_idx, go to ACCUM.
  - Config inputs are ignored outside IDLE.
- ACCUM:
  - o_tile_ready=1; o_accum_valid = i_tile_valid & o_tile_ready, same cycle.
  - Each accepted beat increments channel_idx.
  - The beat accepted with channel_idx==n_channel-1 sets channel_idx to n_channel (held for observation), loads the flush counter with FLUSH_CYCLES, and moves to FLUSH.
  - Gaps in i_tile_valid stall with no other effect.
- FLUSH: o_tile_ready=0. Stays exactly FLUSH_CYCLES cycles, then goes to READ with the read counter and outstanding flag cleared.
- READ:
  - o_read_req pulses one cycle when i_wr_ready=1, outstanding=0 (registered), and issued<READS_PER_GROUP. The pulse sets outstanding and increments issued.
  - i_gather_valid while outstanding=1 clears outstanding and increments completed. i_gather_valid while outstanding=0 is ignored.
  - A completion and the next request cannot share a cycle: minimum spacing between requests is 2 cycles.
  - completed==READS_PER_GROUP moves to NEXT.
- NEXT (1 cycle):
  - Clears channel_idx.
  - If kernel_idx==n_kernel-1, go to DONE.
  - Otherwise increment kernel_idx and go to ACCUM.
- DONE (1 cycle): o_done=1, then IDLE. kernel_idx and channel_idx hold their final values until the next accepted start.
- i_abort:
  - Takes priority over every transition: next state IDLE, counters and outstanding cleared.
  - No o_done pulse. A o_read_req already driven in that cycle is not retracted.
  - An i_start in the same cycle as i_abort is ignored.
- Reset mid-run behaves identically to abort, but asynchronously.
- Width rules: counters saturate at their configured terminal values and never wrap. kernel_idx ranges 0..n_kernel-1.

Test Plan:
- Nominal: n_channel=4, n_kernel=2, continuous valid, i_wr_ready=1, gather_valid 2 cycles after each req.
  - Required: 4 o_accum_valid per group, 3 FLUSH cycles, 4 o_read_req per group, 8 total.
  - Required: o_done one cycle after the 8th completion path through NEXT/DONE; o_busy low afterwards.
- Upstream gaps: i_tile_valid pattern 1,0,0,1,1,0,1 with n_channel=4. Required: exactly 4 strobes; FLUSH entered the cycle after the 7th input cycle.
- Backpressure: i_wr_ready held 0 for 10 cycles in READ, then 1. Required: no o_read_req while low; first request in the first cycle ready=1; a spurious i_gather_valid with no request outstanding does not advance completed.
- Config error: start with n_channel=0, then with n_kernel=17. Required: o_cfg_err pulse each time, o_busy stays 0, no strobes.
- Abort: assert i_abort after 2 completions in kernel 1. Required: IDLE next cycle, counters 0, no o_done; a fresh start with n_channel=1, n_kernel=1 completes normally.
- Max config: n_channel=32, n_kernel=16. Required: 512 strobes, 64 read requests, final o_kernel_idx=15, single o_done.
